seg7_scan_capture: RTL and testbench

- Receive-side counterpart to the BCD-to-7-segment decoder: observes a multiplexed 7-segment display bus (anode select plus segment lines) and recovers the displayed BCD digits.
- Samples the bus and qualifies each anode dwell for stability.
- Decodes each segment pattern back to BCD and assembles a complete multi-digit frame.
- Used for display loop-back self-test and for reading external 7-segment boards.

---
 rtl/seg7_pkg.sv | 60 ++++++
 rtl/seg7_pattern_to_bcd.sv | 19 +
 rtl/seg7_scan_capture.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_capture.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph table (gfedcba, active-high) and its inverse lookup,
// so the forward decoder and the scan-capture block agree on one encoding.
package seg7_pkg;

    typedef enum int unsigned {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F = 5,
        SEG_G = 6
    } seg_idx_e;

    localparam logic [6:0] SEG_PAT_0 = 7'h3F;
    localparam logic [6:0] SEG_PAT_1 = 7'h06;
    localparam logic [6:0] SEG_PAT_2 = 7'h5B;
    localparam logic [6:0] SEG_PAT_3 = 7'h4F;
    localparam logic [6:0] SEG_PAT_4 = 7'h66;
    localparam logic [6:0] SEG_PAT_5 = 7'h6D;
    localparam logic [6:0] SEG_PAT_6 = 7'h7D;
    localparam logic [6:0] SEG_PAT_7 = 7'h07;
    localparam logic [6:0] SEG_PAT_8 = 7'h7F;
    localparam logic [6:0] SEG_PAT_9 = 7'h6F;

    localparam logic [3:0] INVALID_CODE = 4'hF;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } cap_state_e;

    typedef struct packed {
        logic       invalid;
        logic [3:0] code;
    } seg_dec_t;

    function automatic seg_dec_t seg_to_bcd(input logic [6:0] pattern);
        seg_dec_t dec;
        dec.invalid = 1'b0;
        case (pattern)
            SEG_PAT_0: dec.code = 4'd0;
            SEG_PAT_1: dec.code = 4'd1;
            SEG_PAT_2: dec.code = 4'd2;
            SEG_PAT_3: dec.code = 4'd3;
            SEG_PAT_4: dec.code = 4'd4;
            SEG_PAT_5: dec.code = 4'd5;
            SEG_PAT_6: dec.code = 4'd6;
            SEG_PAT_7: dec.code = 4'd7;
            SEG_PAT_8: dec.code = 4'd8;
            SEG_PAT_9: dec.code = 4'd9;
            default: begin
                dec.code    = INVALID_CODE;
                dec.invalid = 1'b1;
            end
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Combinational inverse 7-segment decoder: segment pattern -> {invalid, BCD code}.
module seg7_pattern_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] code_o,
    output logic       invalid_o
);

    seg_dec_t dec;

    always_comb begin
        dec = seg_to_bcd(pattern_i);
    end

    assign code_o    = dec.code;
    assign invalid_o = dec.invalid;

endmodule

// File: rtl/seg7_scan_capture.sv
// Watches a multiplexed 7-segment bus, qualifies each anode dwell for stability
// and reassembles the displayed digits into complete BCD frames.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an_in,
    input  logic [6:0]            seg_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     invalid_out,
    output logic                  frame_valid,
    output logic                  frame_err
);

    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    logic [DIGITS-1:0] an_meta_q, an_s_q, an_prev_q;
    logic [6:0]        seg_meta_q, seg_s_q, seg_prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIGITS-1:0] mask_q;
    logic [TO_W-1:0]   to_q;
    cap_state_e        state_q;

    logic [3:0]          shadow_code_q [DIGITS];
    logic [DIGITS-1:0]   shadow_inv_q;
    logic [4*DIGITS-1:0] shadow_flat;

    logic             same, onehot, capture;
    logic [IDX_W-1:0] cap_idx;
    logic [3:0]       dec_code;
    logic             dec_inv;

    seg7_pattern_to_bcd u_dec (
        .pattern_i (seg_s_q),
        .code_o    (dec_code),
        .invalid_o (dec_inv)
    );

    // The counter saturates at STABLE_CYCLES-1 so a long dwell captures once.
    always_comb begin
        same    = (an_s_q == an_prev_q) && (seg_s_q == seg_prev_q);
        onehot  = $onehot(an_s_q);
        capture = same && onehot && (cnt_q == CNT_FIRE);
        cnt_d   = '0;
        if (same && onehot) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_s_q[i]) begin
                cap_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < DIGITS; i++) begin
            shadow_flat[4*i +: 4] = shadow_code_q[i];
        end
    end

    // Shadow slots are only published once every mask bit has been rewritten.
    always_ff @(posedge clk) begin
        if (capture) begin
            shadow_code_q[cap_idx] <= dec_code;
            shadow_inv_q[cap_idx]  <= dec_inv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta_q   <= '0;
            an_s_q      <= '0;
            an_prev_q   <= '0;
            seg_meta_q  <= '0;
            seg_s_q     <= '0;
            seg_prev_q  <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            to_q        <= '0;
            state_q     <= ST_IDLE;
            bcd_out     <= '0;
            invalid_out <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            an_meta_q   <= an_in;
            an_s_q      <= an_meta_q;
            an_prev_q   <= an_s_q;
            seg_meta_q  <= seg_in;
            seg_s_q     <= seg_meta_q;
            seg_prev_q  <= seg_s_q;
            cnt_q       <= cnt_d;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    to_q <= '0;
                    if (capture) begin
                        mask_q  <= mask_q | an_s_q;
                        state_q <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (&mask_q) begin
                        bcd_out     <= shadow_flat;
                        invalid_out <= shadow_inv_q;
                        frame_valid <= 1'b1;
                        mask_q      <= '0;
                        to_q        <= '0;
                        state_q     <= ST_IDLE;
                    end else if (capture) begin
                        // A capture on the timeout edge wins and restarts the idle count.
                        mask_q <= mask_q | an_s_q;
                        to_q   <= '0;
                    end else if (to_q == TO_LAST) begin
                        frame_err <= 1'b1;
                        mask_q    <= '0;
                        to_q      <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed scans plus random dwells, checked against
// a dwell-level reference model that predicts every frame/timeout pulse.
module tb_seg7_scan_capture;

    localparam int D  = 4;
    localparam int S  = 4;
    localparam int TO = 60;

    localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [D-1:0]  an_in = '0;
    logic [6:0]    seg_in = '0;
    logic [4*D-1:0] bcd_out;
    logic [D-1:0]  invalid_out;
    logic          frame_valid, frame_err;

    seg7_scan_capture #(.DIGITS(D), .STABLE_CYCLES(S), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an_in       (an_in),
        .seg_in      (seg_in),
        .bcd_out     (bcd_out),
        .invalid_out (invalid_out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int         edge_no;
        bit         is_err;
        logic [15:0] bcd;
        logic [3:0]  inv;
    } evt_t;

    evt_t exp_q[$];
    evt_t obs_q[$];

    always @(negedge clk) begin
        if (rst_n && (frame_valid || frame_err)) begin
            evt_t e;
            e.edge_no = edge_n;
            e.is_err  = frame_err;
            e.bcd     = bcd_out;
            e.inv     = invalid_out;
            obs_q.push_back(e);
        end
    end

    // Reference model: one pending dwell plus the partial frame being collected.
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    int          m_start, m_len;
    logic [3:0]  m_mask;
    logic [3:0]  m_code [4];
    logic [3:0]  m_inv_s;
    int          m_last_cap;
    logic [15:0] m_bcd;
    logic [3:0]  m_inv;

    function automatic void ref_decode(input logic [6:0] p, output logic [3:0] code, output logic inv);
        code = 4'hF;
        inv  = 1'b1;
        for (int d = 0; d < 10; d++) begin
            if (GLYPH[d] == p) begin
                code = 4'(d);
                inv  = 1'b0;
            end
        end
    endfunction

    function automatic void model_reset();
        m_an = '0; m_seg = '0; m_start = 0; m_len = 0;
        m_mask = '0; m_inv_s = '0; m_last_cap = 0;
        m_bcd = '0; m_inv = '0;
        for (int i = 0; i < 4; i++) m_code[i] = '0;
    endfunction

    function automatic void model_age(input int e);
        evt_t ev;
        if (m_mask != 0 && e > m_last_cap + TO) begin
            ev.edge_no = m_last_cap + TO;
            ev.is_err  = 1'b1;
            ev.bcd     = m_bcd;
            ev.inv     = m_inv;
            exp_q.push_back(ev);
            m_mask = '0;
        end
    endfunction

    function automatic void model_close();
        int c;
        int idx;
        logic [3:0] code;
        logic inv;
        evt_t ev;
        if (m_len >= S && $onehot(m_an)) begin
            c = m_start + S + 2;
            model_age(c);
            idx = 0;
            for (int i = 0; i < 4; i++) if (m_an[i]) idx = i;
            ref_decode(m_seg, code, inv);
            m_code[idx]  = code;
            m_inv_s[idx] = inv;
            m_mask[idx]  = 1'b1;
            m_last_cap   = c;
            if (m_mask == 4'hF) begin
                m_bcd = {m_code[3], m_code[2], m_code[1], m_code[0]};
                m_inv = m_inv_s;
                ev.edge_no = c + 1;
                ev.is_err  = 1'b0;
                ev.bcd     = m_bcd;
                ev.inv     = m_inv;
                exp_q.push_back(ev);
                m_mask = '0;
            end
        end
    endfunction

    function automatic void model_dwell(input logic [3:0] an, input logic [6:0] seg,
                                        input int start, input int len);
        if (an == m_an && seg == m_seg) begin
            m_len += len;
        end else begin
            model_close();
            m_an = an; m_seg = seg; m_start = start; m_len = len;
        end
    endfunction

    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int len);
        @(negedge clk);
        an_in  = an;
        seg_in = seg;
        model_dwell(an, seg, edge_n, len);
        repeat (len - 1) @(negedge clk);
    endtask

    task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3, input int len);
        dwell(4'b0001, p0, len);
        dwell(4'b0010, p1, len);
        dwell(4'b0100, p2, len);
        dwell(4'b1000, p3, len);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] bcd, input logic [3:0] inv);
        check_val({tag, "_bcd"}, bcd_out, bcd);
        check_val({tag, "_inv"}, invalid_out, inv);
    endtask

    initial begin
        int order [4];
        int tmp, j, n;
        logic [6:0] pat;
        logic [3:0] bad;

        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_bcd", bcd_out, 16'h0);
        check_val("rst_inv", invalid_out, 4'h0);
        check_val("rst_fv", frame_valid, 1'b0);
        check_val("rst_fe", frame_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean scan
        scan4(7'h4F, 7'h5B, 7'h06, 7'h3F, 8);
        dwell(4'b0000, 7'h00, 6);
        check_frame("clean", 16'h0123, 4'h0);

        // Dwells one cycle too short are ignored; exactly STABLE_CYCLES completes
        scan4(7'h07, 7'h7F, 7'h6F, 7'h66, 3);
        dwell(4'b0000, 7'h00, 6);
        check_frame("glitch", 16'h0123, 4'h0);
        scan4(7'h07, 7'h7F, 7'h6F, 7'h66, 4);
        dwell(4'b0000, 7'h00, 6);
        check_frame("stretch", 16'h4987, 4'h0);

        // Illegal glyph on digit 2
        scan4(7'h6D, 7'h7D, 7'h49, 7'h07, 8);
        dwell(4'b0000, 7'h00, 6);
        check_frame("illegal", 16'h7F65, 4'b0100);

        // Zero and multi-hot anode between dwells
        dwell(4'b0001, 7'h3F, 8);
        dwell(4'b0000, 7'h7F, 20);
        dwell(4'b0010, 7'h06, 8);
        dwell(4'b0011, 7'h7F, 20);
        dwell(4'b0100, 7'h5B, 8);
        dwell(4'b0000, 7'h00, 20);
        dwell(4'b1000, 7'h4F, 8);
        dwell(4'b0000, 7'h00, 6);
        check_frame("badan", 16'h3210, 4'h0);

        // Partial frame abandoned by timeout, then a fresh frame
        dwell(4'b0001, 7'h66, 8);
        dwell(4'b0010, 7'h6D, 8);
        dwell(4'b0000, 7'h00, TO + 10);
        check_frame("tmo_hold", 16'h3210, 4'h0);
        scan4(7'h7F, 7'h6F, 7'h3F, 7'h06, 8);
        dwell(4'b0000, 7'h00, 6);
        check_frame("tmo_fresh", 16'h1098, 4'h0);

        // Final capture lands on the timeout edge: frame completes
        dwell(4'b0001, 7'h06, 8);
        dwell(4'b0010, 7'h5B, 8);
        dwell(4'b0100, 7'h4F, TO);
        dwell(4'b1000, 7'h66, 8);
        dwell(4'b0000, 7'h00, 6);
        check_frame("tie", 16'h4321, 4'h0);
        // One cycle later it is a timeout instead
        dwell(4'b0001, 7'h3F, 8);
        dwell(4'b0010, 7'h3F, 8);
        dwell(4'b0100, 7'h3F, TO + 1);
        dwell(4'b1000, 7'h3F, 8);
        dwell(4'b0000, 7'h00, TO + 10);
        check_frame("late", 16'h4321, 4'h0);

        // Reset after two captures
        dwell(4'b0001, 7'h7F, 8);
        dwell(4'b0010, 7'h7F, 8);
        dwell(4'b0000, 7'h00, 10);
        @(negedge clk);
        rst_n  = 1'b0;
        an_in  = '0;
        seg_in = '0;
        model_reset();
        #1;
        check_val("mrst_bcd", bcd_out, 16'h0);
        check_val("mrst_inv", invalid_out, 4'h0);
        check_val("mrst_fv", frame_valid, 1'b0);
        check_val("mrst_fe", frame_err, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        scan4(7'h66, 7'h6D, 7'h7D, 7'h07, 8);
        dwell(4'b0000, 7'h00, 6);
        check_frame("post_rst", 16'h7654, 4'h0);

        // Random scans, odd dwell lengths, bad anodes and long idle gaps
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < 4; i++) order[i] = i;
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(i, 0);
                tmp = order[i]; order[i] = order[j]; order[j] = tmp;
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(99) < 85) pat = GLYPH[$urandom_range(9)];
                else pat = 7'($urandom);
                dwell(4'(1 << order[i]), pat, $urandom_range(9, 2));
                if ($urandom_range(99) < 10) begin
                    bad = 4'($urandom);
                    if ($onehot(bad)) bad = 4'b0000;
                    dwell(bad, 7'($urandom), $urandom_range(25, 1));
                end
                if ($urandom_range(99) < 5) begin
                    dwell(4'b0000, 7'h00, $urandom_range(TO + 8, TO - 4));
                end
            end
        end

        dwell(4'b0000, 7'h00, TO + S + 20);
        @(negedge clk);
        #1;
        model_close();
        model_age(edge_n + 1);

        check_val("final_bcd", bcd_out, m_bcd);
        check_val("final_inv", invalid_out, m_inv);
        check_val("evt_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("evt%0d_edge", i), obs_q[i].edge_no, exp_q[i].edge_no);
            check_val($sformatf("evt%0d_kind", i), obs_q[i].is_err, exp_q[i].is_err);
            check_val($sformatf("evt%0d_bcd", i), obs_q[i].bcd, exp_q[i].bcd);
            check_val($sformatf("evt%0d_inv", i), obs_q[i].inv, exp_q[i].inv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
